ahb_slv_sel16: RTL and testbench
================================

AHB_SLV_SEL16 -- requirements
Module: ahb_slv_sel16

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter: SLV_MAP, default 16'hFFFF, bit n=1 marks region n (haddr[31:28]==n) as populated.
REQ-003 Port: hclk  input  1  bus clock; all state updates on its rising edge.
REQ-004 Port: hreset  input  1  asynchronous active-high reset.
REQ-005 Port: haddr  input  32  address-phase address.
REQ-006 Port: htrans  input  2  transfer type; IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-007 Port: hready  input  1  global HREADY fed back from the response mux output.
REQ-008 Port: hsel  output  16  address-phase one-hot slave select, combinational.
REQ-009 Port: dsel  output  16  registered data-phase one-hot select, driving the 16:1 response/read-data mux selects.
REQ-010 Port: dsel_dflt  output  1  registered data-phase select of the default slave.
REQ-011 Port: dflt_hreadyout  output  1  default-slave HREADYOUT.
REQ-012 Port: dflt_hresp  output  1  default-slave HRESP; 1 means ERROR.

Function
REQ-013 The block SHALL decode idx=haddr[31:28]:
- hsel[idx]=1 when SLV_MAP[idx]=1.
- Otherwise hsel=0 and the access is a default-slave access.
- Decoding is independent of htrans.
REQ-014 When hready=1 at a rising edge, dsel SHALL load the address-phase hsel, and dsel_dflt SHALL load the default-slave decode.
REQ-015 When hready=0, dsel and dsel_dflt SHALL hold.
REQ-016 At most one bit of {dsel,dsel_dflt} SHALL be 1 at any time, and exactly one bit SHALL be 1 after the first edge with hready=1 following reset.
REQ-017 The default slave SHALL use a 3-state FSM: OKAY, ERR1, ERR2.
REQ-018 In OKAY: dflt_hreadyout=1 and dflt_hresp=0.
REQ-019 OKAY->ERR1 SHALL occur when hready=1, the access is a default-slave access, and htrans is NONSEQ or SEQ.
REQ-020 IDLE or BUSY transfers to the default slave SHALL remain in OKAY, giving a zero-wait OKAY.
REQ-021 ERR1 SHALL drive dflt_hreadyout=0 and dflt_hresp=1, and SHALL move to ERR2 unconditionally.
REQ-022 ERR2 SHALL drive dflt_hreadyout=1 and dflt_hresp=1.
REQ-023 From ERR2 the FSM SHALL move to ERR1 if the current address phase (hready=1) is again a default-slave NONSEQ/SEQ, and otherwise to OKAY.
REQ-024 Outputs dflt_hreadyout and dflt_hresp SHALL be decoded from registered state only.
REQ-025 Error response latency SHALL be: address phase at edge N, ERR1 during cycle N..N+1, ERR2 during cycle N+1..N+2.
REQ-026 Back-to-back transfers to different populated slaves SHALL switch dsel in one cycle with no bubble.

Reset
REQ-027 On hreset=1, the block SHALL asynchronously set dsel=16'h0000, dsel_dflt=1 and FSM=OKAY, giving dflt_hreadyout=1 and dflt_hresp=0.
REQ-028 The reset state SHALL guarantee that global hready=1 after reset.
REQ-029 Reset asserted during ERR1 or ERR2 SHALL immediately return the FSM to OKAY.
REQ-030 hsel SHALL remain combinational during reset.

Configuration
REQ-031 Macro AHBL_DFLT_SLV_EN defined: default slave, dsel_dflt and the FSM SHALL be present per REQ-013..REQ-029.
REQ-032 Macro AHBL_DFLT_SLV_EN undefined:
- Unpopulated regions SHALL decode to slave 0 (hsel[0]=1).
- dsel_dflt SHALL be tied to 0, dflt_hreadyout tied to 1 and dflt_hresp tied to 0.
- Reset value of dsel SHALL be 16'h0001.
- No FSM flops SHALL be present.

Verification
REQ-033 Reset release, htrans=IDLE -> dsel=16'h0000, dsel_dflt=1, dflt_hreadyout=1, dflt_hresp=0.
REQ-034 SLV_MAP=16'h00FF, NONSEQ haddr=32'h3000_0000 with hready=1 -> hsel=16'h0008 same cycle, and dsel=16'h0008 after the edge.
REQ-035 SLV_MAP=16'h00FF, NONSEQ haddr=32'hA000_0000 -> next cycle dflt_hreadyout=0 and dflt_hresp=1, following cycle dflt_hreadyout=1 and dflt_hresp=1, then OKAY.
REQ-036 hready=0 held 3 cycles while haddr changes from 32'h1000_0000 to 32'h2000_0000 -> dsel holds 16'h0002.
REQ-037 Two consecutive NONSEQ accesses to unmapped 32'hF000_0000 -> ERR1, ERR2, ERR1, ERR2 with no OKAY gap.
REQ-038 hreset pulsed during ERR1 -> dflt_hreadyout=1, dflt_hresp=0 and dsel_dflt=1 before the next edge; with AHBL_DFLT_SLV_EN undefined, the unmapped access yields hsel=16'h0001.

Source files
------------

// File: rtl/ahb_slv_sel16.sv
// ============================================================================
// Module   : ahb_slv_sel16
// Brief    : AHB-Lite 16-region slave decoder with data-phase select register
//            and optional ERROR-responding default slave (AHBL_DFLT_SLV_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module ahb_slv_sel16 #(
   parameter logic [15:0] SLV_MAP = 16'hFFFF
) (
   input  logic        hclk,
   input  logic        hreset,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic        hready,
   output logic [15:0] hsel,
   output logic [15:0] dsel,
   output logic        dsel_dflt,
   output logic        dflt_hreadyout,
   output logic        dflt_hresp
);

   logic [3:0]  w_idx;
   logic        w_mapped;
   logic        w_unused;

   assign w_idx    = haddr[31:28];
   assign w_mapped = SLV_MAP[w_idx];

`ifdef AHBL_DFLT_SLV_EN

   localparam logic [15:0] c_dsel_rst = 16'h0000;
   localparam logic [1:0]  S_OKAY     = 2'd0;
   localparam logic [1:0]  S_ERR1     = 2'd1;
   localparam logic [1:0]  S_ERR2     = 2'd2;

   logic       w_dflt_acc;
   logic       w_err_start;
   logic [1:0] r_state;
   logic [1:0] w_state_nxt;

   assign w_unused = ^haddr[27:0];

   always_comb begin
      hsel = 16'h0000;
      if (w_mapped) begin
         hsel[w_idx] = 1'b1;
      end
   end

   assign w_dflt_acc  = ~w_mapped;
   // Only NONSEQ/SEQ (htrans[1]=1) real transfers earn an ERROR response
   assign w_err_start = hready & w_dflt_acc & htrans[1];

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         dsel_dflt <= 1'b1;
      end else if (hready) begin
         dsel_dflt <= w_dflt_acc;
      end
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         r_state <= S_OKAY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = S_OKAY;
      case (r_state)
         S_OKAY:  w_state_nxt = w_err_start ? S_ERR1 : S_OKAY;
         S_ERR1:  w_state_nxt = S_ERR2;
         S_ERR2:  w_state_nxt = w_err_start ? S_ERR1 : S_OKAY;
         default: w_state_nxt = S_OKAY;
      endcase
   end

   always_comb begin
      dflt_hreadyout = 1'b1;
      dflt_hresp     = 1'b0;
      case (r_state)
         S_ERR1: begin
            dflt_hreadyout = 1'b0;
            dflt_hresp     = 1'b1;
         end
         S_ERR2: begin
            dflt_hreadyout = 1'b1;
            dflt_hresp     = 1'b1;
         end
         default: begin
            dflt_hreadyout = 1'b1;
            dflt_hresp     = 1'b0;
         end
      endcase
   end

`else

   // Without a default slave, unpopulated regions alias onto slave 0
   localparam logic [15:0] c_dsel_rst = 16'h0001;

   assign w_unused = ^{haddr[27:0], htrans};

   always_comb begin
      hsel = 16'h0000;
      if (w_mapped) begin
         hsel[w_idx] = 1'b1;
      end else begin
         hsel[0] = 1'b1;
      end
   end

   assign dsel_dflt      = 1'b0;
   assign dflt_hreadyout = 1'b1;
   assign dflt_hresp     = 1'b0;

`endif

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         dsel <= c_dsel_rst;
      end else if (hready) begin
         dsel <= hsel;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ahb_slv_sel16.sv
// ============================================================================
// Module   : tb_ahb_slv_sel16
// Brief    : Directed self-checking bench for ahb_slv_sel16 (SLV_MAP=16'h00FF);
//            expectations follow the AHBL_DFLT_SLV_EN setting of the build.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ahb_slv_sel16;

   localparam logic [1:0] c_idle   = 2'd0;
   localparam logic [1:0] c_nonseq = 2'd2;
   localparam logic [1:0] c_seq    = 2'd3;

`ifdef AHBL_DFLT_SLV_EN
   localparam bit          c_dflt_en  = 1'b1;
   localparam logic [15:0] c_dsel_rst = 16'h0000;
   localparam logic [15:0] c_unmap    = 16'h0000;
`else
   localparam bit          c_dflt_en  = 1'b0;
   localparam logic [15:0] c_dsel_rst = 16'h0001;
   localparam logic [15:0] c_unmap    = 16'h0001;
`endif

   logic        hclk;
   logic        hreset;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hready;
   logic [15:0] hsel;
   logic [15:0] dsel;
   logic        dsel_dflt;
   logic        dflt_hreadyout;
   logic        dflt_hresp;

   int n_vec;
   int n_miss;

   ahb_slv_sel16 #(
      .SLV_MAP (16'h00FF)
   ) u_dut (
      .hclk           (hclk),
      .hreset         (hreset),
      .haddr          (haddr),
      .htrans         (htrans),
      .hready         (hready),
      .hsel           (hsel),
      .dsel           (dsel),
      .dsel_dflt      (dsel_dflt),
      .dflt_hreadyout (dflt_hreadyout),
      .dflt_hresp     (dflt_hresp)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive a new address phase away from the rising edge
   task automatic drv(input logic [31:0] a, input logic [1:0] t, input logic r);
      @(negedge hclk);
      haddr  = a;
      htrans = t;
      hready = r;
      #1;
   endtask

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   // Default-slave response expectations for ERR1 / ERR2 / OKAY
   task automatic chk_resp(input string tag, input logic rdy_exp, input logic resp_exp);
      chk({tag, "_rdy"},  {31'd0, dflt_hreadyout}, {31'd0, c_dflt_en ? rdy_exp  : 1'b1});
      chk({tag, "_resp"}, {31'd0, dflt_hresp},     {31'd0, c_dflt_en ? resp_exp : 1'b0});
   endtask

   initial begin
      n_vec  = 0;
      n_miss = 0;
      hreset = 1'b1;
      haddr  = 32'h3000_0000;
      htrans = c_idle;
      hready = 1'b1;

      // Reset state, and hsel stays combinational during reset
      step();
      step();
      chk("rst_dsel",  {16'd0, dsel}, {16'd0, c_dsel_rst});
      chk("rst_dflt",  {31'd0, dsel_dflt}, {31'd0, c_dflt_en});
      chk_resp("rst", 1'b1, 1'b0);
      chk("rst_hsel",  {16'd0, hsel}, 32'h0000_0008);

      drv(32'h0000_0000, c_idle, 1'b1);
      hreset = 1'b0;

      // Decode of region 3, then back-to-back switch to region 5
      drv(32'h3000_0000, c_nonseq, 1'b1);
      chk("r3_hsel", {16'd0, hsel}, 32'h0000_0008);
      step();
      chk("r3_dsel", {16'd0, dsel}, 32'h0000_0008);
      chk("r3_dflt", {31'd0, dsel_dflt}, 32'd0);
      drv(32'h5000_0004, c_seq, 1'b1);
      step();
      chk("r5_dsel", {16'd0, dsel}, 32'h0000_0020);

      // IDLE to an unmapped region: zero-wait OKAY
      drv(32'hA000_0000, c_idle, 1'b1);
      chk("idle_hsel", {16'd0, hsel}, {16'd0, c_unmap});
      step();
      chk("idle_dsel", {16'd0, dsel}, {16'd0, c_unmap});
      chk("idle_dflt", {31'd0, dsel_dflt}, {31'd0, c_dflt_en});
      chk_resp("idle", 1'b1, 1'b0);

      // NONSEQ to unmapped 0xA: ERR1, ERR2, then OKAY
      drv(32'hA000_0000, c_nonseq, 1'b1);
      step();
      chk_resp("a_err1", 1'b0, 1'b1);
      drv(32'h0000_0000, c_idle, c_dflt_en ? 1'b0 : 1'b1);
      step();
      chk_resp("a_err2", 1'b1, 1'b1);
      drv(32'h0000_0000, c_idle, 1'b1);
      step();
      chk_resp("a_okay", 1'b1, 1'b0);
      chk("a_dsel", {16'd0, dsel}, 32'h0000_0001);

      // hready low for 3 cycles: dsel holds region 1
      drv(32'h1000_0000, c_nonseq, 1'b1);
      step();
      chk("h1_dsel", {16'd0, dsel}, 32'h0000_0002);
      for (int i = 0; i < 3; i++) begin
         drv(32'h2000_0000, c_nonseq, 1'b0);
         chk("hold_hsel", {16'd0, hsel}, 32'h0000_0004);
         step();
         chk("hold_dsel", {16'd0, dsel}, 32'h0000_0002);
      end
      drv(32'h2000_0000, c_nonseq, 1'b1);
      step();
      chk("h2_dsel", {16'd0, dsel}, 32'h0000_0004);

      // Two consecutive NONSEQ to unmapped 0xF: ERR1 ERR2 ERR1 ERR2
      drv(32'hF000_0000, c_nonseq, 1'b1);
      step();
      chk_resp("f_err1a", 1'b0, 1'b1);
      drv(32'hF000_0000, c_nonseq, c_dflt_en ? 1'b0 : 1'b1);
      step();
      chk_resp("f_err2a", 1'b1, 1'b1);
      drv(32'hF000_0010, c_nonseq, 1'b1);
      step();
      chk_resp("f_err1b", 1'b0, 1'b1);
      drv(32'h0000_0000, c_idle, c_dflt_en ? 1'b0 : 1'b1);
      step();
      chk_resp("f_err2b", 1'b1, 1'b1);
      drv(32'h0000_0000, c_idle, 1'b1);
      step();
      chk_resp("f_okay", 1'b1, 1'b0);

      // Asynchronous reset pulsed during ERR1
      drv(32'hA000_0000, c_nonseq, 1'b1);
      chk("ar_hsel", {16'd0, hsel}, {16'd0, c_unmap});
      step();
      chk_resp("ar_err1", 1'b0, 1'b1);
      #1;
      hreset = 1'b1;
      #1;
      chk_resp("ar_rst", 1'b1, 1'b0);
      chk("ar_dflt", {31'd0, dsel_dflt}, {31'd0, c_dflt_en});
      chk("ar_dsel", {16'd0, dsel}, {16'd0, c_dsel_rst});
      #1;
      hreset = 1'b0;
      drv(32'h0000_0000, c_idle, 1'b1);
      step();
      chk_resp("ar_post", 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

`default_nettype wire
